// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// ----------------
// Collects up to four committed results per cycle from the ROB. Writes to r0
// are dropped and the remaining lanes are compacted into an in-order FIFO.
// Up to two of the oldest entries are drained per cycle onto the two register
// file write ports. The oldest entry goes to port 0 and the next one to port 1.
// When both drained entries target the same register, only port 1 (the
// younger value) is enabled.
//
// Optional build macro: RF_WRITE_ARBITER_BYPASS_EN
//   When it is defined, a bundle with one or two surviving entries that arrives
//   while the FIFO is empty goes straight into the port registers. This gives a
//   1-cycle latency. When it is undefined, every entry goes through the FIFO,
//   and the minimum latency is 2 cycles.
//
// Ports:
//   clk, res_n            clock, asynchronous active-low reset
//   valid_rob2wa[3:0]     per-lane commit valid, lane 0 oldest
//   reg_rob2wa[23:0]      4 x 6-bit destination register
//   value_rob2wa[255:0]   4 x 64-bit result
//   ready_wa2rob          a full 4-lane bundle can be accepted this cycle
//   write_*_0/1_wa2rf     RF write port 0/1 select, enable, data
//   empty_wa2ctl          FIFO empty and neither port writing
//   count_wa2ctl          current FIFO occupancy
//
// Handshake: the bundle is taken on a rising edge where ready_wa2rob=1 and at
// least one valid bit is set. While ready_wa2rob=0 the ROB holds the bundle
// unchanged. ready_wa2rob is registered, so it never depends combinationally
// on valid_rob2wa.
`timescale 1ns/1ps
module rf_write_arbiter #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic [3:0]       valid_rob2wa,
    input  logic [23:0]      reg_rob2wa,
    input  logic [255:0]     value_rob2wa,
    output logic             ready_wa2rob,
    output logic [5:0]       write_select_0_wa2rf,
    output logic             write_en_0_wa2rf,
    output logic [63:0]      value_0_wa2rf,
    output logic [5:0]       write_select_1_wa2rf,
    output logic             write_en_1_wa2rf,
    output logic [63:0]      value_1_wa2rf,
    output logic             empty_wa2ctl,
    output logic [CNT_W-1:0] count_wa2ctl
);
    localparam int PTR_W = $clog2(DEPTH);
    // A full bundle fits whenever the occupancy is at most DEPTH-4.
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 4);

    logic [5:0]       reg_mem [DEPTH];
    logic [63:0]      val_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d, empty_q, empty_d;
    logic             en0_q, en0_d, en1_q, en1_d;
    logic [5:0]       sel0_q, sel0_d, sel1_q, sel1_d;
    logic [63:0]      val0_q, val0_d, val1_q, val1_d;

    logic             accept;
    logic             bypass;
    logic [2:0]       enq_cnt;
    logic [2:0]       enq_eff;
    logic [1:0]       deq_cnt;
    logic [5:0]       cmp_reg [4];
    logic [63:0]      cmp_val [4];

    assign accept     = ready_q && (valid_rob2wa != 4'b0000);
    assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
    assign deq_cnt    = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];

    // Filter r0 and pack the survivors in lane order into slots 0..enq_cnt-1.
    always_comb begin
        enq_cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            cmp_reg[i] = 6'd0;
            cmp_val[i] = 64'd0;
        end
        for (int i = 0; i < 4; i++) begin
            if (valid_rob2wa[i] && (reg_rob2wa[6*i +: 6] != 6'd0)) begin
                cmp_reg[enq_cnt[1:0]] = reg_rob2wa[6*i +: 6];
                cmp_val[enq_cnt[1:0]] = value_rob2wa[64*i +: 64];
                enq_cnt = enq_cnt + 3'd1;
            end
        end
    end

`ifdef RF_WRITE_ARBITER_BYPASS_EN
    // The FIFO is empty here, so nothing is being drained and the port
    // registers are free for the bundle.
    assign bypass = accept && (count_q == '0) && (enq_cnt != 3'd0) && (enq_cnt <= 3'd2);
`else
    assign bypass = 1'b0;
`endif

    assign enq_eff = (accept && !bypass) ? enq_cnt : 3'd0;

    always_comb begin
        en0_d  = 1'b0;
        en1_d  = 1'b0;
        sel0_d = sel0_q;
        val0_d = val0_q;
        sel1_d = sel1_q;
        val1_d = val1_q;

        // Drain only entries present before this edge. A bundle accepted now
        // is therefore written one cycle later at the earliest.
        if (deq_cnt != 2'd0) begin
            sel0_d = reg_mem[rd_ptr_q];
            val0_d = val_mem[rd_ptr_q];
            en0_d  = 1'b1;
        end
        if (deq_cnt == 2'd2) begin
            sel1_d = reg_mem[rd_ptr_nxt];
            val1_d = val_mem[rd_ptr_nxt];
            en1_d  = 1'b1;
            // Same register twice: suppress the older write so the younger wins.
            if (reg_mem[rd_ptr_nxt] == reg_mem[rd_ptr_q]) begin
                en0_d = 1'b0;
            end
        end

        if (bypass) begin
            sel0_d = cmp_reg[0];
            val0_d = cmp_val[0];
            en0_d  = 1'b1;
            if (enq_cnt == 3'd2) begin
                sel1_d = cmp_reg[1];
                val1_d = cmp_val[1];
                en1_d  = 1'b1;
                if (cmp_reg[1] == cmp_reg[0]) begin
                    en0_d = 1'b0;
                end
            end
        end

        rd_ptr_d = rd_ptr_q + PTR_W'(deq_cnt);
        wr_ptr_d = wr_ptr_q + PTR_W'(enq_eff);
        count_d  = count_q + CNT_W'(enq_eff) - CNT_W'(deq_cnt);
        ready_d  = (count_d <= READY_MAX);
        empty_d  = (count_d == '0) && !en0_d && !en1_d;
    end

    // Storage has no reset. The pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < enq_eff) begin
                reg_mem[wr_ptr_q + PTR_W'(k)] <= cmp_reg[k];
                val_mem[wr_ptr_q + PTR_W'(k)] <= cmp_val[k];
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            empty_q  <= 1'b1;
            en0_q    <= 1'b0;
            en1_q    <= 1'b0;
            sel0_q   <= 6'd0;
            sel1_q   <= 6'd0;
            val0_q   <= 64'd0;
            val1_q   <= 64'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            empty_q  <= empty_d;
            en0_q    <= en0_d;
            en1_q    <= en1_d;
            sel0_q   <= sel0_d;
            sel1_q   <= sel1_d;
            val0_q   <= val0_d;
            val1_q   <= val1_d;
        end
    end

    assign ready_wa2rob         = ready_q;
    assign write_select_0_wa2rf = sel0_q;
    assign write_en_0_wa2rf     = en0_q;
    assign value_0_wa2rf        = val0_q;
    assign write_select_1_wa2rf = sel1_q;
    assign write_en_1_wa2rf     = en1_q;
    assign value_1_wa2rf        = val1_q;
    assign empty_wa2ctl         = empty_q;
    assign count_wa2ctl         = count_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter. Inputs are driven 1ns after a rising edge,
// and outputs are sampled on the falling edge. The monitor pops one expected
// {port, reg, value} entry for every asserted write enable.
`timescale 1ns/1ps
module tb_rf_write_arbiter;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int W     = 71;

    logic             clk = 1'b0;
    logic             res_n;
    logic [3:0]       valid_rob2wa;
    logic [23:0]      reg_rob2wa;
    logic [255:0]     value_rob2wa;
    logic             ready_wa2rob;
    logic [5:0]       write_select_0_wa2rf;
    logic             write_en_0_wa2rf;
    logic [63:0]      value_0_wa2rf;
    logic [5:0]       write_select_1_wa2rf;
    logic             write_en_1_wa2rf;
    logic [63:0]      value_1_wa2rf;
    logic             empty_wa2ctl;
    logic [CNT_W-1:0] count_wa2ctl;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // burst tracking
    logic track = 1'b0;
    logic saw_ready_low;
    int   max_cnt;
    int   drain_cycles;

    logic [23:0]  burst_r;
    logic [255:0] burst_d;

    always #5 clk = ~clk;

    rf_write_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                  (clk),
        .res_n                (res_n),
        .valid_rob2wa         (valid_rob2wa),
        .reg_rob2wa           (reg_rob2wa),
        .value_rob2wa         (value_rob2wa),
        .ready_wa2rob         (ready_wa2rob),
        .write_select_0_wa2rf (write_select_0_wa2rf),
        .write_en_0_wa2rf     (write_en_0_wa2rf),
        .value_0_wa2rf        (value_0_wa2rf),
        .write_select_1_wa2rf (write_select_1_wa2rf),
        .write_en_1_wa2rf     (write_en_1_wa2rf),
        .value_1_wa2rf        (value_1_wa2rf),
        .empty_wa2ctl         (empty_wa2ctl),
        .count_wa2ctl         (count_wa2ctl)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic p, input logic [5:0] r, input logic [63:0] v);
        exp_q.push_back({p, r, v});
    endtask

    task automatic port_check(input logic p, input logic [5:0] s, input logic [63:0] v);
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: port %0d reg %0d value %0h, expected no write", p, s, v);
        end else begin
            e = exp_q.pop_front();
            if ({p, s, v} !== e) begin
                errors++;
                $display("FAIL rf_write: got port %0d reg %0d value %0h expected port %0d reg %0d value %0h",
                         p, s, v, e[70], e[69:64], e[63:0]);
            end
        end
    endtask

    // Monitor: each asserted enable consumes the next expected write.
    always @(negedge clk) begin
        if (write_en_0_wa2rf) port_check(1'b0, write_select_0_wa2rf, value_0_wa2rf);
        if (write_en_1_wa2rf) port_check(1'b1, write_select_1_wa2rf, value_1_wa2rf);
        if (track) begin
            if (!ready_wa2rob) saw_ready_low = 1'b1;
            if (int'(count_wa2ctl) > max_cnt) max_cnt = int'(count_wa2ctl);
            if (write_en_0_wa2rf || write_en_1_wa2rf) drain_cycles++;
        end
    end

    // Call 1ns after a rising edge; returns 1ns after the accepting edge.
    task automatic send(input logic [3:0] v, input logic [23:0] r, input logic [255:0] d);
        int guard;
        valid_rob2wa = v;
        reg_rob2wa   = r;
        value_rob2wa = d;
        guard = 0;
        @(negedge clk);
        while (!ready_wa2rob && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_wa2rob) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready stayed 0 for %0d cycles, expected 1", guard);
        end
        @(posedge clk);
        #1;
        valid_rob2wa = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res_n        = 1'b0;
        valid_rob2wa = 4'b0000;
        reg_rob2wa   = 24'd0;
        value_rob2wa = 256'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_count", 64'(count_wa2ctl), 64'd0);
        check("reset_en0", 64'(write_en_0_wa2rf), 64'd0);
        check("reset_en1", 64'(write_en_1_wa2rf), 64'd0);
        check("reset_ready", 64'(ready_wa2rob), 64'd1);
        check("reset_empty", 64'(empty_wa2ctl), 64'd1);
        check("reset_sel0", 64'(write_select_0_wa2rf), 64'd0);
        check("reset_val1", value_1_wa2rf, 64'd0);
        res_n = 1'b1;
        @(posedge clk);
        #1;

        // Mid-stream reset with five entries buffered.
        expect_wr(1'b0, 6'd20, 64'h20);
        expect_wr(1'b1, 6'd21, 64'h21);
        send(4'b1111, {6'd23, 6'd22, 6'd21, 6'd20}, {64'h23, 64'h22, 64'h21, 64'h20});
        send(4'b0111, {6'd0, 6'd26, 6'd25, 6'd24}, {64'h0, 64'h26, 64'h25, 64'h24});
        @(negedge clk);
        check("midstream_count", 64'(count_wa2ctl), 64'd5);
        check("midstream_ready", 64'(ready_wa2rob), 64'd0);
        res_n = 1'b0;
        @(posedge clk);
        #1;
        check("inreset_count", 64'(count_wa2ctl), 64'd0);
        check("inreset_en0", 64'(write_en_0_wa2rf), 64'd0);
        check("inreset_en1", 64'(write_en_1_wa2rf), 64'd0);
        @(negedge clk);
        res_n = 1'b1;
        repeat (3) @(negedge clk);
        check("postreset_count", 64'(count_wa2ctl), 64'd0);
        check("postreset_ready", 64'(ready_wa2rob), 64'd1);
        check("postreset_empty", 64'(empty_wa2ctl), 64'd1);
        @(posedge clk);
        #1;

        // Single lane r5 = 0xAA.
        expect_wr(1'b0, 6'd5, 64'hAA);
        send(4'b0001, {6'd0, 6'd0, 6'd0, 6'd5}, {64'd0, 64'd0, 64'd0, 64'hAA});
`ifndef RF_WRITE_ARBITER_BYPASS_EN
        @(negedge clk);
        check("single_early_en0", 64'(write_en_0_wa2rf), 64'd0);
        check("single_count", 64'(count_wa2ctl), 64'd1);
`endif
        @(negedge clk);
        check("single_en0", 64'(write_en_0_wa2rf), 64'd1);
        check("single_sel0", 64'(write_select_0_wa2rf), 64'd5);
        check("single_val0", value_0_wa2rf, 64'hAA);
        check("single_en1", 64'(write_en_1_wa2rf), 64'd0);
        check("single_count_after", 64'(count_wa2ctl), 64'd0);
        @(negedge clk);
        check("single_pulse_en0", 64'(write_en_0_wa2rf), 64'd0);
        check("single_empty", 64'(empty_wa2ctl), 64'd1);
        @(posedge clk);
        #1;

        // {r3=1, r0=2, r7=3, r9=4}: r0 dropped.
        expect_wr(1'b0, 6'd3, 64'd1);
        expect_wr(1'b1, 6'd7, 64'd3);
        expect_wr(1'b0, 6'd9, 64'd4);
        send(4'b1111, {6'd9, 6'd7, 6'd0, 6'd3}, {64'd4, 64'd3, 64'd2, 64'd1});
        @(negedge clk);
        check("filter_count", 64'(count_wa2ctl), 64'd3);
        check("filter_empty", 64'(empty_wa2ctl), 64'd0);
        @(negedge clk);
        check("filter_pair_en0", 64'(write_en_0_wa2rf), 64'd1);
        check("filter_pair_en1", 64'(write_en_1_wa2rf), 64'd1);
        check("filter_count_mid", 64'(count_wa2ctl), 64'd1);
        @(negedge clk);
        check("filter_tail_sel0", 64'(write_select_0_wa2rf), 64'd9);
        check("filter_tail_en1", 64'(write_en_1_wa2rf), 64'd0);
        check("filter_count_end", 64'(count_wa2ctl), 64'd0);
        @(posedge clk);
        #1;

        // Collision: lanes 0/1 both r12, younger value 0x22 wins on port 1.
        expect_wr(1'b1, 6'd12, 64'h22);
        send(4'b0011, {6'd0, 6'd0, 6'd12, 6'd12}, {64'd0, 64'd0, 64'h22, 64'h11});
`ifndef RF_WRITE_ARBITER_BYPASS_EN
        @(negedge clk);
`endif
        @(negedge clk);
        check("collide_en0", 64'(write_en_0_wa2rf), 64'd0);
        check("collide_en1", 64'(write_en_1_wa2rf), 64'd1);
        check("collide_sel1", 64'(write_select_1_wa2rf), 64'd12);
        check("collide_val1", value_1_wa2rf, 64'h22);
        repeat (2) @(posedge clk);
        #1;

        // Four back-to-back full bundles, regs 1..16.
        for (int n = 1; n <= 16; n++) expect_wr(1'((n - 1) % 2), 6'(n), 64'h100 + 64'(n));
        saw_ready_low = 1'b0;
        max_cnt       = 0;
        drain_cycles  = 0;
        track         = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int l = 0; l < 4; l++) begin
                burst_r[6*l +: 6]   = 6'(4*b + l + 1);
                burst_d[64*l +: 64] = 64'h100 + 64'(4*b + l + 1);
            end
            send(4'b1111, burst_r, burst_d);
        end
        repeat (12) @(negedge clk);
        track = 1'b0;
        check("burst_ready_dropped", 64'(saw_ready_low), 64'd1);
        check("burst_max_count", 64'(max_cnt), 64'd6);
        check("burst_drain_cycles", 64'(drain_cycles), 64'd8);
        check("burst_count_end", 64'(count_wa2ctl), 64'd0);
        check("burst_empty_end", 64'(empty_wa2ctl), 64'd1);
        @(posedge clk);
        #1;

`ifdef RF_WRITE_ARBITER_BYPASS_EN
        expect_wr(1'b0, 6'd4, 64'h5);
        send(4'b0001, {6'd0, 6'd0, 6'd0, 6'd4}, {64'd0, 64'd0, 64'd0, 64'h5});
        @(negedge clk);
        check("bypass_en0", 64'(write_en_0_wa2rf), 64'd1);
        check("bypass_sel0", 64'(write_select_0_wa2rf), 64'd4);
        check("bypass_count", 64'(count_wa2ctl), 64'd0);
        @(posedge clk);
        #1;
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Sits between ROB commit and the register file's two write ports.
- Accepts up to 4 committed results per cycle from ROB, in program order.
- Drops writes to r0, buffers the rest in an in-order FIFO, and drains up to 2 per cycle onto RF write ports 0/1.
- Resolves same-register collisions within a drain pair so the younger value wins deterministically.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 4.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  in  1  clock
- res_n  in  1  asynchronous active-low reset
- valid_rob2wa  in  4  per-lane commit valid; lane 0 oldest
- reg_rob2wa  in  24  4x6-bit destination register, lane i at [6i+5:6i]
- value_rob2wa  in  256  4x64-bit result, lane i at [64i+63:64i]
- ready_wa2rob  out  1  arbiter can accept a full 4-lane bundle this cycle
- write_select_0_wa2rf  out  6  RF port 0 register
- write_en_0_wa2rf  out  1  RF port 0 enable
- value_0_wa2rf  out  64  RF port 0 data
- write_select_1_wa2rf  out  6  RF port 1 register
- write_en_1_wa2rf  out  1  RF port 1 enable
- value_1_wa2rf  out  64  RF port 1 data
- empty_wa2ctl  out  1  FIFO empty and no write on either port
- count_wa2ctl  out  CNT_W  current FIFO occupancy

Behaviour:
- Reset (async, res_n=0):
  - Pointers, count and all output registers cleared: enables 0, selects 0, values 0, count 0.
  - ready_wa2rob=1, empty_wa2ctl=1.
  - Reset mid-operation discards all buffered entries.
- Accept:
  - Bundle accepted on posedge when ready_wa2rob=1 and any valid bit is set.
  - ROB must hold the bundle unchanged while ready=0.
  - Valid bits need not be contiguous.
- Filter and compact:
  - Lanes with reg=0 are discarded (never enqueued, never counted).
  - Remaining lanes are compacted in lane order and written to consecutive slots starting at the write pointer.
  - Pointers wrap modulo DEPTH.
- Drain (same cycle):
  - Up to min(count, 2) oldest entries are popped.
  - Popped entries are registered onto the RF ports at the next posedge.
  - Oldest entry goes to port 0, next entry to port 1.
  - Single entry: port 0 only, write_en_1=0.
- Collision: if both popped entries target the same register, write_en_0=0 and port 1 carries the younger entry. Both still count as popped.
- Latency without bypass: bundle accepted at edge t, visible in FIFO after t, earliest RF write asserted after edge t+1.
- Occupancy:
  - count_next = count + enq - deq, where enq is 0..4 and deq is 0..2.
  - Simultaneous enqueue and dequeue are legal in the same cycle.
- Ready (registered):
  - ready_wa2rob <= (DEPTH - count_next >= 4).
  - Full/overflow cannot occur.
  - Empty FIFO pops nothing; outputs then show enables=0, select/value hold last value.
- empty_wa2ctl (registered) = (count_next==0) && no enable asserted next cycle.
- Enable outputs are single-cycle pulses per drained entry.

Optional Feature:
- Macro: RF_WRITE_ARBITER_BYPASS_EN.
- Defined:
  - If the FIFO is empty (count=0) at an accepting edge and the filtered bundle has <=2 entries, they go straight to the RF port registers on that edge.
  - Not enqueued; count unchanged; 1-cycle latency.
  - Collision rule still applies.
  - Bundles with 3 or 4 filtered entries, or any bundle when count>0, take the normal path.
- Not defined: all entries take the FIFO path (2-cycle minimum latency).

Test Plan:
- Reset mid-stream with count=5, release -> count=0, both enables 0, ready=1, empty=1; no further writes.
- Single lane 0 {r5, 0xAA} (no bypass) -> write_en_0=1, select_0=5, value_0=0xAA two edges after accept, write_en_1=0; count returns 0.
- Bundle {r3=1, r0=2, r7=3, r9=4}, all valid -> r0 dropped, count=3; drain r3/r7 on ports 0/1, then r9 on port 0 next cycle.
- Lanes 0/1 both r12, values 0x11 then 0x22 -> write_en_0=0, write_en_1=1, select_1=12, value_1=0x22.
- Four consecutive full bundles (16 regs 1..16) with DEPTH=8 -> ready drops once count>4; all 16 regs written in order over 8 drain cycles; no loss or duplication.
- With RF_WRITE_ARBITER_BYPASS_EN and empty FIFO, accept {r4=0x5} -> write_en_0=1, select_0=4 one edge after accept; count stays 0.
